// File: rtl/aes_inv_round_ctrl_pkg.sv
// Shared definitions for the iterative AES inverse-cipher sequencer:
// block geometry, round counts, controller state encoding and GF(2^8) helpers.
package aes_inv_round_ctrl_pkg;

    localparam int AES_BLK_W  = 128;
    localparam int AES_NR_128 = 10;
    localparam int AES_NR_192 = 12;
    localparam int AES_NR_256 = 14;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ROUND,
        ST_FINAL,
        ST_DONE
    } ctrl_state_e;

    // Multiply by x modulo the AES polynomial x^8 + x^4 + x^3 + x + 1.
    function automatic logic [7:0] gf_xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] acc;
        logic [7:0] p;
        acc = '0;
        p   = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) acc = acc ^ p;
            p = gf_xtime(p);
        end
        return acc;
    endfunction

endpackage

// File: rtl/aes_inv_round_ctrl_if.sv
// Block source, plaintext sink and key-store lookup bundled for the controller.
interface aes_inv_round_ctrl_if #(
    parameter int KIDX_W = 4
);
    import aes_inv_round_ctrl_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [0:AES_BLK_W-1] in_data;
    logic [KIDX_W-1:0]    rk_idx;
    logic [0:AES_BLK_W-1] rk_data;
    logic                 out_valid;
    logic                 out_ready;
    logic [0:AES_BLK_W-1] out_data;

    modport master (
        input  in_valid, in_data, rk_data, out_ready,
        output in_ready, rk_idx, out_valid, out_data
    );

    modport slave (
        output in_valid, in_data, rk_data, out_ready,
        input  in_ready, rk_idx, out_valid, out_data
    );

endinterface

// File: rtl/aes_inv_round_dp.sv
// Combinational inverse round: InvShiftRows, InvSubBytes, AddRoundKey, then
// InvMixColumns unless this is the last round.
module aes_inv_round_dp
    import aes_inv_round_ctrl_pkg::*;
(
    input  logic [0:AES_BLK_W-1] s,
    input  logic [0:AES_BLK_W-1] rk,
    input  logic                 last,
    output logic [0:AES_BLK_W-1] result
);

    // Inverse affine map followed by the field inverse computed as x^254.
    function automatic logic [7:0] inv_sbox(input logic [7:0] b);
        logic [7:0] a, x2, x3, x12, x15, x240;
        a    = {b[6:0], b[7]} ^ {b[4:0], b[7:5]} ^ {b[1:0], b[7:2]} ^ 8'h05;
        x2   = gf_mul(a, a);
        x3   = gf_mul(x2, a);
        x12  = gf_mul(gf_mul(x3, x3), gf_mul(x3, x3));
        x15  = gf_mul(x12, x3);
        x240 = gf_mul(x15, x15);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        x240 = gf_mul(x240, x240);
        return gf_mul(gf_mul(x240, x12), x2);
    endfunction

    function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
        logic [7:0] a0, a1, a2, a3;
        {a0, a1, a2, a3} = col;
        return {gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09),
                gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d),
                gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b),
                gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e)};
    endfunction

    logic [0:AES_BLK_W-1] ark;

    // Byte i = row (i%4), column (i/4); row r is rotated right by r columns.
    always_comb begin
        ark    = '0;
        result = '0;
        for (int i = 0; i < 16; i++) begin
            ark[8*i +: 8] = inv_sbox(s[8*((i % 4) + 4*(((i / 4) - (i % 4) + 4) % 4)) +: 8])
                          ^ rk[8*i +: 8];
        end
        for (int c = 0; c < 4; c++) begin
            result[32*c +: 32] = last ? ark[32*c +: 32] : inv_mix_col(ark[32*c +: 32]);
        end
    end

endmodule

// File: rtl/aes_inv_round_ctrl.sv
// Iterative AES inverse-cipher sequencer: owns the block register, walks the
// round-key index from NR down to 0 and hands the plaintext to the sink.
module aes_inv_round_ctrl
    import aes_inv_round_ctrl_pkg::*;
#(
    parameter int NR     = AES_NR_128,
    parameter int KIDX_W = 4
) (
    input  logic                 clk,
    input  logic                 reset_n,
    aes_inv_round_ctrl_if.master bus,
    input  logic                 abort,
    output logic                 busy
);

    localparam logic [KIDX_W-1:0] RND_NR  = KIDX_W'(NR);
    localparam logic [KIDX_W-1:0] RND_ONE = KIDX_W'(1);

    ctrl_state_e          state, state_d;
    logic [KIDX_W-1:0]    rnd, rnd_d;
    logic [0:AES_BLK_W-1] blk, blk_d;
    logic [0:AES_BLK_W-1] dp_out;
    logic                 last_round;

    assign last_round = (state == ST_FINAL);

    aes_inv_round_dp u_dp (
        .s      (blk),
        .rk     (bus.rk_data),
        .last   (last_round),
        .result (dp_out)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            rnd   <= RND_NR;
            blk   <= '0;
        end else begin
            state <= state_d;
            rnd   <= rnd_d;
            blk   <= blk_d;
        end
    end

    // abort overrides everything, including an acceptance offered in IDLE.
    always_comb begin
        state_d = state;
        rnd_d   = rnd;
        blk_d   = blk;
        if (abort) begin
            state_d = ST_IDLE;
            rnd_d   = RND_NR;
            blk_d   = '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (bus.in_valid) begin
                        blk_d   = bus.in_data ^ bus.rk_data;
                        rnd_d   = KIDX_W'(NR - 1);
                        state_d = (NR == 1) ? ST_FINAL : ST_ROUND;
                    end
                end
                ST_ROUND: begin
                    blk_d = dp_out;
                    rnd_d = rnd - RND_ONE;
                    if (rnd == RND_ONE) state_d = ST_FINAL;
                end
                ST_FINAL: begin
                    blk_d   = dp_out;
                    rnd_d   = RND_NR;
                    state_d = ST_DONE;
                end
                ST_DONE: begin
                    if (bus.out_ready) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state == ST_IDLE);
    assign bus.out_valid = (state == ST_DONE);
    assign bus.out_data  = blk;
    assign bus.rk_idx    = rnd;
    assign busy          = (state != ST_IDLE);

endmodule

// File: tb/tb_aes_inv_round_ctrl.sv
// Bench for aes_inv_round_ctrl: forward-cipher reference model produces ciphertexts,
// the DUT must recover the plaintexts with the required timing and handshakes.
module tb_aes_inv_round_ctrl;

    typedef struct {
        logic [0:127] key;
        logic [0:127] ct;
        logic [0:127] pt;
    } vec_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic abort = 1'b0;
    logic busy10, busy14;

    int n_vec = 0;
    int n_bad = 0;

    logic [7:0]   sbox   [0:255];
    logic [31:0]  w      [0:59];
    logic [0:127] ek     [0:15];
    logic [0:127] rk10   [0:15];
    logic [0:127] rk14   [0:15];
    int           idx_log[0:39];
    vec_t         vt     [8];

    aes_inv_round_ctrl_if #(.KIDX_W(4)) b10 ();
    aes_inv_round_ctrl_if #(.KIDX_W(4)) b14 ();

    assign b10.rk_data = rk10[b10.rk_idx];
    assign b14.rk_data = rk14[b14.rk_idx];

    aes_inv_round_ctrl #(.NR(10), .KIDX_W(4)) dut10 (
        .clk(clk), .reset_n(reset_n), .bus(b10), .abort(abort), .busy(busy10));
    aes_inv_round_ctrl #(.NR(14), .KIDX_W(4)) dut14 (
        .clk(clk), .reset_n(reset_n), .bus(b14), .abort(1'b0), .busy(busy14));

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want $finish");
        $fatal(1, "watchdog");
    end

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b, want %b", name, act, exp);
        end
    endtask

    task automatic checki(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endtask

    task automatic checkv(input string name, input logic [0:127] act, input logic [0:127] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, want %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ---------------- reference model (forward cipher) ----------------
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r, x;
        r = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) r = r ^ x;
            x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
        end
        return r;
    endfunction

    function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
        logic [15:0] d;
        d = {b, b} << n;
        return d[15:8];
    endfunction

    task automatic build_sbox();
        logic [7:0] inv, bx;
        for (int x = 0; x < 256; x++) begin
            bx  = 8'(x);
            inv = 8'h00;
            for (int y = 1; y < 256; y++)
                if (gmul(bx, 8'(y)) == 8'h01) inv = 8'(y);
            sbox[x] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
        end
    endtask

    function automatic logic [31:0] subw(input logic [31:0] x);
        return {sbox[x[31:24]], sbox[x[23:16]], sbox[x[15:8]], sbox[x[7:0]]};
    endfunction

    task automatic expand(input logic [0:255] key, input int nk, input int nr);
        logic [31:0] t;
        logic [7:0]  rcon;
        rcon = 8'h01;
        for (int i = 0; i < nk; i++) w[i] = key[32*i +: 32];
        for (int i = nk; i < 4*(nr+1); i++) begin
            t = w[i-1];
            if (i % nk == 0) begin
                t    = subw({t[23:0], t[31:24]}) ^ {rcon, 24'h0};
                rcon = gmul(rcon, 8'h02);
            end else if (nk > 6 && i % nk == 4) begin
                t = subw(t);
            end
            w[i] = w[i-nk] ^ t;
        end
        for (int r = 0; r <= nr; r++) ek[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
    endtask

    function automatic logic [0:127] encrypt(input logic [0:127] pt, input int nr);
        logic [7:0]   s [16];
        logic [7:0]   t [16];
        logic [0:127] o;
        for (int i = 0; i < 16; i++) s[i] = pt[8*i +: 8] ^ ek[0][8*i +: 8];
        for (int r = 1; r <= nr; r++) begin
            for (int i = 0; i < 16; i++) t[i] = sbox[s[(i % 4) + 4*(((i / 4) + (i % 4)) % 4)]];
            for (int c = 0; c < 4; c++) begin
                if (r < nr) begin
                    s[4*c]   = gmul(t[4*c], 8'h02) ^ gmul(t[4*c+1], 8'h03) ^ t[4*c+2] ^ t[4*c+3];
                    s[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 8'h02) ^ gmul(t[4*c+2], 8'h03) ^ t[4*c+3];
                    s[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 8'h02) ^ gmul(t[4*c+3], 8'h03);
                    s[4*c+3] = gmul(t[4*c], 8'h03) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 8'h02);
                end else begin
                    for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
                end
            end
            for (int i = 0; i < 16; i++) s[i] = s[i] ^ ek[r][8*i +: 8];
        end
        for (int i = 0; i < 16; i++) o[8*i +: 8] = s[i];
        return o;
    endfunction

    function automatic logic [0:127] rnd128();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // ---------------- NR=10 drivers ----------------
    task automatic load10(input logic [0:127] key);
        expand({key, 128'h0}, 4, 10);
        for (int r = 0; r <= 10; r++) rk10[r] = ek[r];
    endtask

    task automatic send10(input logic [0:127] ct);
        int n;
        n = 0;
        while (b10.in_ready !== 1'b1 && n < 40) begin
            tick();
            n++;
        end
        check1("in_ready_before_accept", b10.in_ready, 1'b1);
        checki("rk_idx_idle", int'(b10.rk_idx), 10);
        b10.in_data  = ct;
        b10.in_valid = 1'b1;
        tick();
        b10.in_valid = 1'b0;
    endtask

    task automatic wait_out10(output int lat);
        lat = 0;
        while (b10.out_valid !== 1'b1 && lat < 40) begin
            idx_log[lat] = int'(b10.rk_idx);
            tick();
            lat++;
        end
    endtask

    task automatic run10(input vec_t v, input int stall);
        int lat;
        logic ok;
        load10(v.key);
        b10.out_ready = (stall == 0);
        send10(v.ct);
        wait_out10(lat);
        checki("latency", lat, 10);
        checkv("plaintext", b10.out_data, v.pt);
        ok = 1'b1;
        for (int k = 0; k < 10; k++) if (idx_log[k] != 9 - k) ok = 1'b0;
        check1("rk_idx_sequence", ok, 1'b1);
        for (int s = 0; s < stall; s++) begin
            tick();
            check1("hold_out_valid", b10.out_valid, 1'b1);
            checkv("hold_out_data", b10.out_data, v.pt);
            check1("hold_in_ready_low", b10.in_ready, 1'b0);
        end
        b10.out_ready = 1'b1;
        tick();
        check1("after_handshake_in_ready", b10.in_ready, 1'b1);
        check1("after_handshake_out_valid", b10.out_valid, 1'b0);
    endtask

    initial begin
        int           lat;
        logic         seen;
        logic [0:127] pt2, ct2;
        logic [0:255] k14 [2];
        logic [0:127] c14 [2];
        logic [0:127] p14 [2];

        b10.in_valid = 1'b0; b10.in_data = '0; b10.out_ready = 1'b1;
        b14.in_valid = 1'b0; b14.in_data = '0; b14.out_ready = 1'b1;
        for (int r = 0; r < 16; r++) begin
            rk10[r] = '0;
            rk14[r] = '0;
        end

        build_sbox();
        vt[0].key = 128'h000102030405060708090a0b0c0d0e0f;
        vt[0].ct  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
        vt[0].pt  = 128'h00112233445566778899aabbccddeeff;
        for (int i = 1; i < 8; i++) begin
            vt[i].key = rnd128();
            vt[i].pt  = rnd128();
            expand({vt[i].key, 128'h0}, 4, 10);
            vt[i].ct  = encrypt(vt[i].pt, 10);
        end

        // Reset values while reset_n is held low
        tick();
        tick();
        check1("reset_in_ready", b10.in_ready, 1'b1);
        check1("reset_out_valid", b10.out_valid, 1'b0);
        checkv("reset_out_data", b10.out_data, 128'h0);
        check1("reset_busy", busy10, 1'b0);
        checki("reset_rk_idx", int'(b10.rk_idx), 10);
        checki("reset_rk_idx_nr14", int'(b14.rk_idx), 14);
        reset_n = 1'b1;
        tick();

        // Table of vectors: C.1 then model-generated ones, with random backpressure
        for (int i = 0; i < 8; i++) run10(vt[i], int'($urandom_range(0, 2)));

        // Backpressure: five stalled cycles
        run10(vt[0], 5);

        // Back-to-back with in_valid held high and out_ready tied high
        load10(vt[0].key);
        pt2 = rnd128();
        ct2 = encrypt(pt2, 10);
        b10.out_ready = 1'b1;
        b10.in_data   = vt[0].ct;
        b10.in_valid  = 1'b1;
        tick();
        b10.in_data = ct2;
        wait_out10(lat);
        checki("b2b_latency_1", lat, 10);
        checkv("b2b_plaintext_1", b10.out_data, vt[0].pt);
        tick();
        check1("b2b_ready_after_handshake", b10.in_ready, 1'b1);
        tick();
        check1("b2b_second_accepted", busy10, 1'b1);
        check1("b2b_in_ready_low", b10.in_ready, 1'b0);
        b10.in_valid = 1'b0;
        wait_out10(lat);
        checki("b2b_latency_2", lat, 10);
        checkv("b2b_plaintext_2", b10.out_data, pt2);
        tick();
        check1("b2b_idle", b10.in_ready, 1'b1);

        // abort in the fifth ROUND cycle
        send10(vt[0].ct);
        repeat (4) tick();
        abort = 1'b1;
        tick();
        abort = 1'b0;
        check1("abort_busy", busy10, 1'b0);
        check1("abort_in_ready", b10.in_ready, 1'b1);
        checki("abort_rk_idx", int'(b10.rk_idx), 10);
        checkv("abort_cleared", b10.out_data, 128'h0);
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (b10.out_valid === 1'b1) seen = 1'b1;
        end
        check1("abort_no_out_valid", seen, 1'b0);

        // abort in IDLE wins over an offered block
        abort        = 1'b1;
        b10.in_data  = vt[0].ct;
        b10.in_valid = 1'b1;
        tick();
        abort        = 1'b0;
        b10.in_valid = 1'b0;
        check1("abort_idle_not_accepted", busy10, 1'b0);
        run10(vt[0], 0);

        // Asynchronous reset between edges during ROUND
        send10(vt[0].ct);
        repeat (3) tick();
        #2 reset_n = 1'b0;
        #1;
        check1("async_in_ready", b10.in_ready, 1'b1);
        check1("async_busy", busy10, 1'b0);
        check1("async_out_valid", b10.out_valid, 1'b0);
        checkv("async_out_data", b10.out_data, 128'h0);
        checki("async_rk_idx", int'(b10.rk_idx), 10);
        tick();
        reset_n = 1'b1;
        tick();
        run10(vt[0], 1);

        // NR=14 instance: FIPS-197 C.3 plus one model-generated AES-256 vector
        k14[0] = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
        c14[0] = 128'h8ea2b7ca516745bfeafc49904b496089;
        p14[0] = 128'h00112233445566778899aabbccddeeff;
        k14[1] = {rnd128(), rnd128()};
        p14[1] = rnd128();
        expand(k14[1], 8, 14);
        c14[1] = encrypt(p14[1], 14);
        for (int i = 0; i < 2; i++) begin
            expand(k14[i], 8, 14);
            for (int r = 0; r <= 14; r++) rk14[r] = ek[r];
            check1("nr14_in_ready", b14.in_ready, 1'b1);
            b14.in_data  = c14[i];
            b14.in_valid = 1'b1;
            tick();
            b14.in_valid = 1'b0;
            lat = 0;
            while (b14.out_valid !== 1'b1 && lat < 40) begin
                tick();
                lat++;
            end
            checki("nr14_latency", lat, 14);
            checkv("nr14_plaintext", b14.out_data, p14[i]);
            tick();
            check1("nr14_idle", b14.in_ready, 1'b1);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
